// File: rtl/cache_axi_pkg.sv
// Shared constants and types for the icache AXI read bridge.
// Holds AXI field encodings, line geometry and the refill FSM state enum.
package cache_axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int LINE_BYTES = 64;
    localparam int LINE_WORDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_DRAIN
    } rd_state_e;

endpackage

// File: rtl/icache_axi_rd_bridge_rd_out_stage.sv
// One-entry output register for returned refill beats.
// Ports: load/load_data/load_last in, ret_ready in; ret_valid/ret_last/ret_data out,
// can_load out (stage empty or being drained this cycle).
module rd_out_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              ret_ready,
    output logic              ret_valid,
    output logic              ret_last,
    output logic [DATA_W-1:0] ret_data,
    output logic              can_load
);

    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign can_load  = !valid_q || ret_ready;
    assign ret_valid = valid_q;
    assign ret_last  = last_q;
    assign ret_data  = data_q;

    // A load in the same cycle as a consume replaces the entry.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            last_d  = load_last;
            data_d  = load_data;
        end else if (valid_q && ret_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/icache_axi_rd_bridge.sv
// Read-only AXI4 master turning one icache line refill into a 16-beat INCR burst.
// Ports: cache side r_req/r_addr/r_rdy, ret_valid/ret_last/r_data_AXI, r_data_ready, err;
// AXI side AR channel (araddr..arready) and R channel (rdata..rready).
module icache_axi_rd_bridge #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 16,
    parameter int ID_W       = 4,
    parameter int AR_ID      = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_rdy,
    input  logic              r_data_ready,
    output logic              ret_valid,
    output logic              ret_last,
    output logic [31:0]       r_data_AXI,
    output logic              err,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [ID_W-1:0]   arid,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic [ID_W-1:0]   rid,
    input  logic              rvalid,
    output logic              rready
);

    import cache_axi_pkg::*;

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

    rd_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              err_q, err_d;

    logic stage_free;
    logic r_hs;
    logic is_last;
    logic addr_unused;

    // Line offset bits never reach the bus.
    assign addr_unused = ^r_addr[OFF_W-1:0];

    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign arid    = ID_W'(AR_ID);
    assign araddr  = araddr_q;
    assign arvalid = (state_q == ST_AR);
    assign r_rdy   = arvalid && arready;
    assign err     = err_q;

    assign rready  = (state_q == ST_R) && stage_free;
    assign r_hs    = rvalid && rready;
    assign is_last = (cnt_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        araddr_d = araddr_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (r_req) begin
                    araddr_d = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    state_d  = ST_AR;
                end
            end
            ST_AR: begin
                if (arready) begin
                    cnt_d   = '0;
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (r_hs) begin
                    // Wraps to zero exactly as the last beat leaves.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (ret_valid && r_data_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Protocol faults are flagged only; the beat stream is untouched.
        if (r_hs && ((rresp != RESP_OKAY) ||
                     (rid != ID_W'(AR_ID)) ||
                     (rlast != is_last))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            araddr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            araddr_q <= araddr_d;
            err_q    <= err_d;
        end
    end

    rd_out_stage #(
        .DATA_W(32)
    ) u_out (
        .clk      (clk),
        .rstn     (rstn),
        .load     (r_hs),
        .load_data(rdata),
        .load_last(is_last),
        .ret_ready(r_data_ready),
        .ret_valid(ret_valid),
        .ret_last (ret_last),
        .ret_data (r_data_AXI),
        .can_load (stage_free)
    );

endmodule

// File: doc/icache_axi_rd_bridge.md
# icache_axi_rd_bridge

Read-only AXI4 master bridge between the instruction cache's refill port and the system AXI interconnect. Takes one line-refill request at a time, issues a 16-beat INCR burst on AR, registers returning R beats through a one-entry output stage, and presents them to the cache as `ret_valid`/`ret_last`/`r_data_AXI`. Checks beat count against `rlast` and records protocol or response errors.

## Interface
- `ADDR_W`, 32, address width
- `LINE_WORDS`, 16, 32-bit beats per cache line (512-bit line)
- `ID_W`, 4, AXI ID width
- `AR_ID`, 0, constant `arid` value
- `clk`  in  1  clock; all logic on the rising edge
- `rstn`  in  1  reset; synchronous and active-high (1 = reset). Name matches the cache port.
- `r_req`  in  1  refill request from the cache; held until `r_rdy`
- `r_addr`  in  ADDR_W  refill address; the low 6 bits are ignored
- `r_rdy`  out  1  one-cycle pulse: request accepted by AXI (AR handshake done)
- `r_data_ready`  in  1  cache can accept a returned beat
- `ret_valid`  out  1  returned beat valid
- `ret_last`  out  1  final beat of the line; qualified by `ret_valid`
- `r_data_AXI`  out  32  returned beat data
- `err`  out  1  sticky error flag; cleared only by reset
- `araddr`  out  ADDR_W; `arlen`  out  8; `arsize`  out  3; `arburst`  out  2; `arid`  out  ID_W; `arvalid`  out  1; `arready`  in  1
- `rdata`  in  32; `rresp`  in  2; `rlast`  in  1; `rid`  in  ID_W; `rvalid`  in  1; `rready`  out  1

## Operation
- FSM states: IDLE, AR, R, DRAIN.
- **IDLE**
  - On `r_req`, latch `{r_addr[ADDR_W-1:6],6'b0}` into `araddr`, then go to AR.
- **AR**
  - `arvalid`=1. Fields are constant: `arlen`=LINE_WORDS-1 (15), `arsize`=2, `arburst`=2'b01, `arid`=AR_ID.
  - When `arvalid && arready`: pulse `r_rdy`, clear the beat counter, go to R.
  - `araddr` is stable while `arvalid` is high.
- **R**
  - `rready = !ret_valid || r_data_ready`.
  - Each R handshake loads the output stage with `rdata`, sets `ret_valid`, sets `ret_last` = (beat count == LINE_WORDS-1), and increments the 4-bit counter.
  - The output stage clears `ret_valid` when `ret_valid && r_data_ready` and no new beat loads in the same cycle.
  - Handshake on the last beat: go to DRAIN.
- **DRAIN**
  - `rready`=0. Wait for the last beat to be consumed (`ret_valid && r_data_ready`), then go to IDLE.
- **Errors** (set `err`; the data flow continues unchanged)
  - `rresp != 2'b00`.
  - `rid != AR_ID`.
  - `rlast` = 1 on beats 0..14.
  - `rlast` = 0 on beat 15.
- `ret_last` always follows the counter, never `rlast`, so the cache always receives exactly LINE_WORDS beats.
- `r_req` is ignored outside IDLE. Only one outstanding burst at a time.

## Timing
- Reset values: all outputs 0. FSM=IDLE, counter=0, `err`=0. `arlen`/`arsize`/`arburst`/`arid` are constants.
- A reset asserted mid-burst returns to IDLE immediately and drops `ret_valid`. Orphaned R beats are not tracked; system reset covers the interconnect.
- Request path latency:
  - `r_req` high in cycle t gives `arvalid` high in t+1.
  - `r_rdy` pulses in the cycle of the AR handshake.
- Beat latency: R handshake in cycle t gives `ret_valid` with that data in t+1.
- Throughput: one beat per cycle while `r_data_ready`=1. A 16-beat line completes in 16 cycles plus 1 after the first `rvalid`.
- Simultaneous consume and load in R: the new beat replaces the old one and `ret_valid` stays 1.
- Counter wrap: the 4-bit counter wraps 15→0 only at the transition to DRAIN.

## Structure
- Shared package `cache_axi_pkg`:
  - AXI constants: `BURST_INCR`=2'b01, `SIZE_4B`=3'b010, `RESP_OKAY`=2'b00.
  - `LINE_BYTES`=64, `LINE_WORDS`=16.
  - FSM state enum.
- One natural sub-module: `rd_out_stage`, the one-entry ret data/valid/last register with the ready logic.

## Test plan
- Basic refill, `arready`=1, `rvalid` every cycle, `r_data_ready`=1:
  - `r_addr`=0x1C00_0044 gives `araddr`=0x1C00_0040, `arlen`=15, and `r_rdy` one cycle.
  - 16 `ret_valid` beats carry data 0..15 in order; `ret_last` is set only on beat 15.
  - FSM returns to IDLE and `err`=0.
- AR backpressure: `arready` low for 5 cycles.
  - `arvalid` and `araddr` stay stable.
  - `r_rdy` pulses exactly once, in the handshake cycle.
- R backpressure: `r_data_ready` toggles 1/0 each cycle.
  - No beat is lost or duplicated; `rready` stays low while the stage is full and not consumed.
  - All 16 words arrive in order.
- Bad response: `rresp`=2'b10 on beat 3.
  - All 16 beats are still delivered and `err`=1 afterwards.
- Early `rlast` on beat 7, then beats 8–15 supplied:
  - `err`=1.
  - `ret_last` is asserted only on the 16th beat.
- Reset at beat 9:
  - Next cycle has `ret_valid`=0, `err`=0, FSM in IDLE.
  - A following request completes normally.
